// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: instruction sequencer FSM, decode of ALU/immediate/register selects,
// NZCV flag register and condition-execute gating of every architectural write enable.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         Cond,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ResultSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUControl,
  output logic [STATE_W-1:0] o_dbg_state,
  output logic [3:0]         o_dbg_flags,
  output logic               o_dbg_cond_ok
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD    = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR    = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_UNKNOWN  = STATE_W'(10);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [3:0]         r_flags;
  logic               r_cond_ok;

  logic       w_cond_ex;
  logic       w_alu_op;
  logic       w_reg_w;
  logic       w_mem_w;
  logic       w_branch;
  logic       w_no_write;
  logic       w_cv_upd;
  logic [1:0] w_dp_ctrl;
  logic       w_execute;
  logic       w_reg_write;

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:    w_next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   w_next_state = S_MEMADR;
          2'b00:   w_next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   w_next_state = S_BRANCH;
          default: w_next_state = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   w_next_state = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next_state = S_MEMWB;
      S_EXECUTER: w_next_state = S_ALUWB;
      S_EXECUTEI: w_next_state = S_ALUWB;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Condition check against the flags as they stand when the instruction is decoded.
  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
      4'b0000: w_cond_ex = r_flags[2];
      4'b0001: w_cond_ex = ~r_flags[2];
      4'b0010: w_cond_ex = r_flags[1];
      4'b0011: w_cond_ex = ~r_flags[1];
      4'b0100: w_cond_ex = r_flags[3];
      4'b0101: w_cond_ex = ~r_flags[3];
      4'b0110: w_cond_ex = r_flags[0];
      4'b0111: w_cond_ex = ~r_flags[0];
      4'b1000: w_cond_ex = r_flags[1] & ~r_flags[2];
      4'b1001: w_cond_ex = ~r_flags[1] | r_flags[2];
      4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
      4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
      4'b1100: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'b1101: w_cond_ex = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // NoWrite only has meaning for data-processing; memory Funct bits carry P/U/B/W instead.
  always_comb begin
    w_dp_ctrl  = 2'b00;
    w_no_write = 1'b0;
    w_cv_upd   = 1'b0;
    case (Funct[4:1])
      4'b0100: begin w_dp_ctrl = 2'b00; w_cv_upd = 1'b1; end
      4'b0010: begin w_dp_ctrl = 2'b01; w_cv_upd = 1'b1; end
      4'b0000: w_dp_ctrl = 2'b10;
      4'b1100: w_dp_ctrl = 2'b11;
      4'b1010: begin w_dp_ctrl = 2'b01; w_cv_upd = 1'b1; w_no_write = (Op == 2'b00); end
      default: begin w_dp_ctrl = 2'b00; w_no_write = (Op == 2'b00); end
    endcase
  end

  always_comb begin
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    w_alu_op  = 1'b0;
    w_reg_w   = 1'b0;
    w_mem_w   = 1'b0;
    w_branch  = 1'b0;
    case (r_state)
      S_FETCH, S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMRD:    AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_reg_w   = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        w_mem_w = 1'b1;
      end
      S_EXECUTER: w_alu_op = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB  = 2'b01;
        w_alu_op = 1'b1;
      end
      S_ALUWB:    w_reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_execute   = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);
  assign w_reg_write = w_reg_w & r_cond_ok & ~w_no_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_flags   <= 4'b0000;
      r_cond_ok <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE)
        r_cond_ok <= w_cond_ex;
      if (w_execute && r_cond_ok && Funct[0]) begin
        r_flags[3:2] <= ALUFlags[3:2];
        if (w_cv_upd)
          r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Write enables are held low for the whole time reset is asserted, including the abort cycle.
  assign ALUControl = w_alu_op ? w_dp_ctrl : 2'b00;
  assign ImmSrc     = (Op == 2'b11) ? 2'b00 : Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign IRWrite    = ~reset & (r_state == S_FETCH);
  assign RegWrite   = ~reset & w_reg_write;
  assign MemWrite   = ~reset & w_mem_w & r_cond_ok;
  assign PCWrite    = ~reset & ((r_state == S_FETCH) |
                      (r_cond_ok & (w_branch | (w_reg_write & (Rd == 4'hF)))));

  assign o_dbg_state   = r_state;
  assign o_dbg_flags   = r_flags;
  assign o_dbg_cond_ok = r_cond_ok;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instructions then random ones, each checked cycle by
// cycle against per-instruction-class expectations and an architectural NZCV flag model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0] dbg_state;
  logic [3:0] dbg_flags;
  logic       dbg_cond_ok;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .o_dbg_state(dbg_state), .o_dbg_flags(dbg_flags), .o_dbg_cond_ok(dbg_cond_ok)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] m_flags;
  bit         use_force = 1'b0;
  logic [3:0] af_force  = 4'b0000;
  logic [3:0] dp_cmds[5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

  logic [15:0] ctrl_word;
  assign ctrl_word = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
                      ImmSrc, RegSrc, ALUControl};

  task automatic check16(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected control word; ImmSrc/RegSrc follow from the instruction class alone.
  function automatic logic [15:0] mk(input logic pcw, input logic mw, input logic rw, input logic irw,
                                     input logic adr, input logic [1:0] res, input logic srca,
                                     input logic [1:0] srcb, input logic [1:0] alu, input logic [1:0] op);
    logic [1:0] imm;
    logic [1:0] rsrc;
    imm  = (op == 2'b11) ? 2'b00 : op;
    rsrc = {op == 2'b01, op == 2'b10};
    return {pcw, mw, rw, irw, adr, res, srca, srcb, imm, rsrc, alu};
  endfunction

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;            4'h1: return !z;
      4'h2: return cy;           4'h3: return !cy;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return cy && !z;     4'h9: return !cy || z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input logic [15:0] exp, input string tag);
    @(negedge clk);
    check16(ctrl_word, exp, tag);
    @(posedge clk);
    #1;
    ALUFlags = use_force ? af_force : 4'($urandom);
  endtask

  // Called at #1 after the edge that enters FETCH; returns at the same point of the next FETCH.
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input string name);
    logic       c_ok, rw, nw, cv;
    logic [1:0] alu;
    logic [3:0] af;
    Cond = cond; Op = op; Funct = funct; Rd = rd;
    step(mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00, op), {name, "_fetch"});
    c_ok = cond_holds(cond, m_flags);
    step(mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, op), {name, "_decode"});
    case (op)
      2'b01: begin
        step(mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, op), {name, "_memadr"});
        if (funct[0]) begin
          step(mk(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, op), {name, "_memrd"});
          rw = c_ok;
          step(mk(rw && rd == 4'hF, 0, rw, 0, 0, 2'b01, 0, 2'b00, 2'b00, op), {name, "_memwb"});
        end else begin
          step(mk(0, c_ok, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, op), {name, "_memwr"});
        end
      end
      2'b00: begin
        nw = 1'b0; cv = 1'b0; alu = 2'b00;
        case (funct[4:1])
          4'b0100: begin alu = 2'b00; cv = 1'b1; end
          4'b0010: begin alu = 2'b01; cv = 1'b1; end
          4'b0000: alu = 2'b10;
          4'b1100: alu = 2'b11;
          4'b1010: begin alu = 2'b01; cv = 1'b1; nw = 1'b1; end
          default: nw = 1'b1;
        endcase
        af = ALUFlags;
        step(mk(0, 0, 0, 0, 0, 2'b00, 0, funct[5] ? 2'b01 : 2'b00, alu, op), {name, "_execute"});
        if (c_ok && funct[0]) begin
          m_flags[3:2] = af[3:2];
          if (cv) m_flags[1:0] = af[1:0];
        end
        rw = c_ok && !nw;
        step(mk(rw && rd == 4'hF, 0, rw, 0, 0, 2'b00, 0, 2'b00, 2'b00, op), {name, "_aluwb"});
      end
      2'b10: step(mk(c_ok, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, op), {name, "_branch"});
      default: step(mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, op), {name, "_unknown"});
    endcase
    check16({12'b0, dbg_flags}, {12'b0, m_flags}, {name, "_flags"});
  endtask

  initial begin
    int         sel;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;

    reset = 1'b1; Cond = 4'h0; Op = 2'b00; Funct = 6'h00; Rd = 4'h0; ALUFlags = 4'h0;
    m_flags = 4'b0000;
    repeat (2) begin
      @(negedge clk);
      check16({12'b0, PCWrite, MemWrite, RegWrite, IRWrite}, 16'h0, "reset_enables");
    end
    check16({12'b0, dbg_state}, 16'h0, "reset_state");
    check16({12'b0, dbg_flags}, 16'h0, "reset_flags");
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(4'hE, 2'b00, 6'b101000, 4'h1, "add_imm");
    run_instr(4'hE, 2'b01, 6'b011001, 4'h3, "ldr");
    run_instr(4'hE, 2'b01, 6'b011000, 4'h4, "str");

    use_force = 1'b1; af_force = 4'b0100; ALUFlags = 4'b0100;
    run_instr(4'hE, 2'b00, 6'b010101, 4'h0, "cmp");
    check16({12'b0, dbg_flags}, 16'h0004, "cmp_flags_const");
    use_force = 1'b0;
    run_instr(4'h0, 2'b10, 6'($urandom), 4'h0, "beq_taken");
    run_instr(4'h1, 2'b10, 6'($urandom), 4'h0, "bne_not_taken");
    run_instr(4'hE, 2'b00, 6'b001000, 4'hF, "add_to_pc");
    run_instr(4'hE, 2'b11, 6'($urandom), 4'h2, "op_unknown");
    run_instr(4'hF, 2'b00, 6'b001000, 4'h5, "cond_never");

    // Abort a store in its write cycle; Z is still set from the compare, so flags clearing is visible.
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'h6;
    step(mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00, 2'b01), "abort_fetch");
    step(mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b01), "abort_decode");
    step(mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01), "abort_memadr");
    #1;
    check16({15'b0, MemWrite}, 16'h1, "memwr_before_reset");
    reset = 1'b1;
    #1;
    check16({12'b0, PCWrite, MemWrite, RegWrite, IRWrite}, 16'h0, "abort_enables");
    check16({12'b0, dbg_state}, 16'h0, "abort_state");
    check16({12'b0, dbg_flags}, 16'h0, "abort_flags");
    m_flags = 4'b0000;
    @(negedge clk);
    check16({12'b0, PCWrite, MemWrite, RegWrite, IRWrite}, 16'h0, "abort_hold_enables");
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(4'hE, 2'b00, 6'b101000, 4'h1, "post_reset_add");

    for (int i = 0; i < 40; i++) begin
      sel  = $urandom_range(0, 9);
      op   = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      cond = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) cond = 4'hE;
      case (op)
        2'b00:   funct = {1'($urandom), dp_cmds[$urandom_range(0, 4)], 1'($urandom)};
        2'b01:   funct = {5'b01100, 1'($urandom)};
        default: funct = 6'($urandom);
      endcase
      run_instr(cond, op, funct, 4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
